// File: rtl/bar_graph_writer.sv
// Per-row event counters that are flushed once per frame, during vertical blanking,
// into the bar-graph visualizer RAM through its tg_* write port.
module bar_graph_writer #(
  parameter int SCREEN_HEIGHT = 42,
  parameter int SCREEN_WIDTH  = 76,
  parameter int VBLANK_START  = 720
) (
  input  logic                             pixel_clk_in,
  input  logic                             rst_in,
  input  logic [10:0]                      hcount_in,
  input  logic [9:0]                       vcount_in,
  input  logic                             sample_valid_in,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0] sample_bin_in,
  output logic                             sample_ready_out,
  input  logic                             clear_in,
  input  logic                             clear_on_flush_in,
  output logic                             tg_write_en,
  output logic [$clog2(SCREEN_HEIGHT)-1:0] tg_addr,
  output logic [31:0]                      tg_input,
  output logic                             flush_done_out
);
  localparam int BIN_W = $clog2(SCREEN_HEIGHT);
  localparam int CNT_W = $clog2(SCREEN_WIDTH + 1);
  localparam logic [BIN_W-1:0] LAST_ROW = BIN_W'(SCREEN_HEIGHT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCREEN_WIDTH);

  typedef enum logic [1:0] {IDLE, FLUSH, DONE, CLEAR} state_t;

  state_t r_state, w_state_n;

  logic [SCREEN_HEIGHT-1:0][CNT_W-1:0] w_count;

  logic             r_we, r_done, r_ready, r_cof;
  logic [BIN_W-1:0] r_addr;
  logic [31:0]      r_data;

  logic             w_we_n, w_done_n, w_cof_n;
  logic             w_wr, w_clr_all, w_accept, w_trig;
  logic [BIN_W-1:0] w_row, w_addr_n;
  logic [31:0]      w_data_n;

  assign w_accept = sample_valid_in && r_ready;
  assign w_trig   = (hcount_in == 11'd0) && (vcount_in == 10'(VBLANK_START));

  // w_row is the row registered onto the write port at this edge.
  always_comb begin
    w_state_n = r_state;
    w_cof_n   = r_cof;
    w_wr      = 1'b0;
    w_row     = '0;
    w_clr_all = 1'b0;
    w_done_n  = 1'b0;
    case (r_state)
      IDLE: begin
        if (clear_in) begin
          w_state_n = CLEAR;
        end else if (w_trig) begin
          w_state_n = FLUSH;
          w_cof_n   = clear_on_flush_in;
          w_wr      = 1'b1;
        end
      end
      FLUSH: begin
        if (r_addr == LAST_ROW) begin
          w_state_n = DONE;
          w_done_n  = 1'b1;
        end else begin
          w_wr  = 1'b1;
          w_row = r_addr + BIN_W'(1);
        end
      end
      DONE: w_state_n = IDLE;
      CLEAR: begin
        w_state_n = IDLE;
        w_clr_all = 1'b1;
      end
      default: w_state_n = IDLE;
    endcase
    w_we_n   = w_wr;
    w_addr_n = w_wr ? w_row : r_addr;
    w_data_n = w_wr ? 32'(w_count[w_row]) : r_data;
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_state_n;
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ready <= 1'b0;
      r_cof   <= 1'b0;
    end else begin
      r_we    <= w_we_n;
      r_addr  <= w_addr_n;
      r_data  <= w_data_n;
      r_done  <= w_done_n;
      r_ready <= (w_state_n != CLEAR);
      r_cof   <= w_cof_n;
    end
  end

  // A clear-on-flush of a row that is also sampled on the same edge keeps that sample.
  for (genvar g = 0; g < SCREEN_HEIGHT; g++) begin : g_row
    logic [CNT_W-1:0] r_cnt;
    logic             w_hit, w_wclr;

    assign w_hit   = w_accept && (sample_bin_in == BIN_W'(g));
    assign w_wclr  = w_wr && w_cof_n && (w_row == BIN_W'(g));
    assign w_count[g] = r_cnt;

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in)                         r_cnt <= '0;
      else if (w_clr_all)                 r_cnt <= '0;
      else if (w_wclr)                    r_cnt <= w_hit ? CNT_W'(1) : '0;
      else if (w_hit && r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tg_write_en      = r_we;
  assign tg_addr          = r_addr;
  assign tg_input         = r_data;
  assign flush_done_out   = r_done;
  assign sample_ready_out = r_ready;
endmodule
